// File: rtl/sram_controller.sv
// Single-word controller for an asynchronous 16-bit SRAM with programmable wait states.
// Optional write-verify readback is enabled by defining SRAM_WRITE_VERIFY_EN.
module sram_controller #(
    parameter int ADDR_W      = 24,
    parameter int SRAM_ADDR_W = 18,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [ADDR_W-1:0]      wr_addr,
    input  logic [15:0]            wr_data,
    input  logic                   wr_enable,
    input  logic [ADDR_W-1:0]      rd_addr,
    input  logic                   rd_enable,
    output logic [15:0]            rd_data,
    output logic                   rd_ready,
    output logic                   busy,
    output logic                   wr_error,
    output logic [SRAM_ADDR_W-1:0] sram_addr,
    inout  wire  [15:0]            sram_dq,
    output logic                   sram_ce_n,
    output logic                   sram_oe_n,
    output logic                   sram_we_n,
    output logic                   sram_ub_n,
    output logic                   sram_lb_n
);

    localparam logic [3:0] PULSE_LD = 4'(WAIT_CYCLES - 1);
    localparam logic [3:0] ACC_LD   = 4'(WAIT_CYCLES);

    typedef enum logic [2:0] {
        IDLE,
        WR_SETUP,
        WR_PULSE,
        WR_HOLD,
        RD_ACCESS,
        RD_TURN
`ifdef SRAM_WRITE_VERIFY_EN
        ,
        VFY_ACCESS,
        VFY_TURN
`endif
    } state_t;

    state_t                 state_q, state_d;
    logic [3:0]             cnt_q, cnt_d;
    logic [SRAM_ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]            wdata_q, wdata_d;
    logic [15:0]            rd_data_q, rd_data_d;
    logic                   rd_ready_q, rd_ready_d;
    logic                   busy_q, busy_d;
    logic                   wr_error_q, wr_error_d;
    logic                   ce_n_q, ce_n_d;
    logic                   oe_n_q, oe_n_d;
    logic                   we_n_q, we_n_d;
    logic                   bs_n_q, bs_n_d;
    logic                   dq_oe_q, dq_oe_d;
`ifdef SRAM_WRITE_VERIFY_EN
    logic [15:0]            vfy_q, vfy_d;
`endif

    // Upper request address bits alias onto the same SRAM word by design.
    logic unused_addr_hi;
    assign unused_addr_hi = ^{wr_addr[ADDR_W-1:SRAM_ADDR_W], rd_addr[ADDR_W-1:SRAM_ADDR_W]};

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rd_data_d  = rd_data_q;
        rd_ready_d = 1'b0;
        wr_error_d = wr_error_q;
`ifdef SRAM_WRITE_VERIFY_EN
        vfy_d      = vfy_q;
`endif
        case (state_q)
            IDLE: begin
                if (wr_enable) begin
                    state_d = WR_SETUP;
                    addr_d  = wr_addr[SRAM_ADDR_W-1:0];
                    wdata_d = wr_data;
                end else if (rd_enable) begin
                    state_d = RD_ACCESS;
                    addr_d  = rd_addr[SRAM_ADDR_W-1:0];
                    cnt_d   = ACC_LD;
                end
            end
            WR_SETUP: begin
                state_d = WR_PULSE;
                cnt_d   = PULSE_LD;
            end
            WR_PULSE: begin
                if (cnt_q == 4'd0) state_d = WR_HOLD;
                else               cnt_d   = cnt_q - 4'd1;
            end
            WR_HOLD: begin
`ifdef SRAM_WRITE_VERIFY_EN
                state_d = VFY_ACCESS;
                cnt_d   = ACC_LD;
`else
                state_d = IDLE;
`endif
            end
            RD_ACCESS: begin
                if (cnt_q == 4'd0) begin
                    state_d   = RD_TURN;
                    rd_data_d = sram_dq;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RD_TURN: begin
                state_d    = IDLE;
                rd_ready_d = 1'b1;
            end
`ifdef SRAM_WRITE_VERIFY_EN
            VFY_ACCESS: begin
                if (cnt_q == 4'd0) begin
                    state_d = VFY_TURN;
                    vfy_d   = sram_dq;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            VFY_TURN: begin
                state_d = IDLE;
                if (vfy_q != wdata_q) wr_error_d = 1'b1;
            end
`endif
            default: state_d = IDLE;
        endcase

        // Pin values are derived from the next state so every SRAM pin is a flop output.
        busy_d  = (state_d != IDLE);
        dq_oe_d = (state_d == WR_SETUP) || (state_d == WR_PULSE) || (state_d == WR_HOLD);
        oe_n_d  = !(state_d == RD_ACCESS
`ifdef SRAM_WRITE_VERIFY_EN
                    || state_d == VFY_ACCESS
`endif
                   );
        ce_n_d  = !(dq_oe_d || !oe_n_d);
        we_n_d  = (state_d != WR_PULSE);
        bs_n_d  = ce_n_d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            addr_q     <= '0;
            rd_data_q  <= 16'd0;
            rd_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            wr_error_q <= 1'b0;
            ce_n_q     <= 1'b1;
            oe_n_q     <= 1'b1;
            we_n_q     <= 1'b1;
            bs_n_q     <= 1'b1;
            dq_oe_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            rd_data_q  <= rd_data_d;
            rd_ready_q <= rd_ready_d;
            busy_q     <= busy_d;
            wr_error_q <= wr_error_d;
            ce_n_q     <= ce_n_d;
            oe_n_q     <= oe_n_d;
            we_n_q     <= we_n_d;
            bs_n_q     <= bs_n_d;
            dq_oe_q    <= dq_oe_d;
        end
    end

    always_ff @(posedge clk) begin
        wdata_q <= wdata_d;
`ifdef SRAM_WRITE_VERIFY_EN
        vfy_q   <= vfy_d;
`endif
    end

    assign sram_dq   = dq_oe_q ? wdata_q : 16'hzzzz;
    assign sram_addr = addr_q;
    assign sram_ce_n = ce_n_q;
    assign sram_oe_n = oe_n_q;
    assign sram_we_n = we_n_q;
    assign sram_ub_n = bs_n_q;
    assign sram_lb_n = bs_n_q;
    assign rd_data   = rd_data_q;
    assign rd_ready  = rd_ready_q;
    assign busy      = busy_q;
`ifdef SRAM_WRITE_VERIFY_EN
    assign wr_error  = wr_error_q;
`else
    assign wr_error  = 1'b0;
    logic unused_err;
    assign unused_err = wr_error_q | wr_error_d;
`endif

endmodule

// File: tb/tb_sram_controller.sv
// Bench for sram_controller: behavioural SRAM model, vector table, read scoreboard.
module tb_sram_controller;

    localparam int W = 2;
`ifdef SRAM_WRITE_VERIFY_EN
    localparam int EXP_WR_BUSY = 2 * W + 4;
`else
    localparam int EXP_WR_BUSY = W + 2;
`endif
    localparam int EXP_RD_BUSY = W + 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [23:0] wr_addr, rd_addr;
    logic [15:0] wr_data;
    logic        wr_enable, rd_enable;
    logic [15:0] rd_data;
    logic        rd_ready, busy, wr_error;
    logic [17:0] sram_addr;
    wire  [15:0] sram_dq;
    logic        sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n;

    sram_controller #(.ADDR_W(24), .SRAM_ADDR_W(18), .WAIT_CYCLES(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .wr_addr(wr_addr), .wr_data(wr_data), .wr_enable(wr_enable),
        .rd_addr(rd_addr), .rd_enable(rd_enable),
        .rd_data(rd_data), .rd_ready(rd_ready), .busy(busy), .wr_error(wr_error),
        .sram_addr(sram_addr), .sram_dq(sram_dq),
        .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n),
        .sram_ub_n(sram_ub_n), .sram_lb_n(sram_lb_n)
    );

    always #5 clk = ~clk;

    // Asynchronous SRAM model; optional bit-0 stuck-at-0 on reads.
    logic [15:0] mem [0:(1<<18)-1];
    logic        stuck0 = 1'b0;
    logic        mdl_drive;
    logic [15:0] mdl_q;
    assign mdl_drive = !sram_ce_n && !sram_oe_n && sram_we_n;
    assign mdl_q     = mem[sram_addr] & (stuck0 ? 16'hFFFE : 16'hFFFF);
    assign sram_dq   = mdl_drive ? mdl_q : 16'hzzzz;
    always @(posedge clk) begin
        if (!sram_ce_n && !sram_we_n) mem[sram_addr] <= sram_dq;
    end

    int compared = 0;
    int mismatched = 0;
    logic [15:0] sb_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic run_access(input bit wr, input bit also_rd, input logic [23:0] addr,
                              input logic [15:0] data, input logic [17:0] pin, input int exp_busy);
        int busy_n, we_low, oe_low;
        bit dq_bad, pin_bad, we_in_oe, done;
        logic [15:0] exp;
        @(negedge clk);
        wr_enable = wr;
        rd_enable = !wr || also_rd;
        wr_addr = addr; rd_addr = addr; wr_data = data;
        if (!wr) sb_q.push_back(data);
        @(negedge clk);
        wr_enable = 1'b0; rd_enable = 1'b0;
        busy_n = 0; we_low = 0; oe_low = 0;
        dq_bad = 0; pin_bad = 0; we_in_oe = 0; done = 0;
        for (int c = 0; c < 200 && !done; c++) begin
            if (c > 0) @(negedge clk);
            if (rd_ready) begin
                if (sb_q.size() == 0) check("spurious_rd_ready", 32'd1, 32'd0);
                else begin
                    exp = sb_q.pop_front();
                    check("rd_data", {16'd0, rd_data}, {16'd0, exp});
                    check("busy_with_rd_ready", {31'd0, busy}, 32'd0);
                end
            end
            if (!busy) done = 1;
            else begin
                busy_n++;
                if (!sram_we_n) begin
                    we_low++;
                    if (sram_dq !== data) dq_bad = 1;
                end
                if (!sram_oe_n) begin
                    oe_low++;
                    if (!sram_we_n) we_in_oe = 1;
                end
                if (!sram_ce_n && (sram_addr !== pin || sram_ub_n || sram_lb_n)) pin_bad = 1;
            end
        end
        if (!done) check("busy_timeout", 32'd0, 32'd1);
        check(wr ? "wr_busy_cycles" : "rd_busy_cycles", busy_n, exp_busy);
        if (wr) begin
            check("we_low_cycles", we_low, W);
            check("wr_dq_value", {31'd0, dq_bad}, 32'd0);
        end else begin
            check("oe_low_cycles", oe_low, W + 1);
            check("rd_we_low", we_low, 0);
            check("rd_ready_missing", sb_q.size(), 0);
        end
        check("addr_or_byte_strobes", {31'd0, pin_bad}, 32'd0);
        check("we_during_oe", {31'd0, we_in_oe}, 32'd0);
        @(negedge clk);
        check("rd_ready_one_cycle", {31'd0, rd_ready}, 32'd0);
    endtask

    typedef struct {
        bit          wr;
        logic [23:0] addr;
        logic [15:0] data;
        logic [17:0] pin;
    } vec_t;
    vec_t vt[9];

    initial begin
        for (int i = 0; i < (1 << 18); i++) mem[i] = 16'h0000;
        vt[0] = '{1'b1, 24'h000123, 16'hBEEF, 18'h00123};
        vt[1] = '{1'b0, 24'h000123, 16'hBEEF, 18'h00123};
        vt[2] = '{1'b1, 24'hFC0005, 16'hA5A5, 18'h00005};
        vt[3] = '{1'b0, 24'h000005, 16'hA5A5, 18'h00005};
        vt[4] = '{1'b1, 24'h03FFFF, 16'h5A5A, 18'h3FFFF};
        vt[5] = '{1'b0, 24'h3FFFFF, 16'h5A5A, 18'h3FFFF};
        vt[6] = '{1'b1, 24'h000041, 16'h2222, 18'h00041};
        vt[7] = '{1'b1, 24'h000040, 16'h1111, 18'h00040};
        vt[8] = '{1'b0, 24'h000041, 16'h2222, 18'h00041};

        rst_n = 1'b0; wr_enable = 1'b0; rd_enable = 1'b0;
        wr_addr = '0; rd_addr = '0; wr_data = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_rd_ready", {31'd0, rd_ready}, 32'd0);
        check("rst_rd_data", {16'd0, rd_data}, 32'd0);
        check("rst_wr_error", {31'd0, wr_error}, 32'd0);
        check("rst_sram_addr", {14'd0, sram_addr}, 32'd0);
        check("rst_strobes", {27'd0, sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n}, 32'h1F);
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++)
            run_access(vt[i].wr, 1'b0, vt[i].addr, vt[i].data, vt[i].pin,
                       vt[i].wr ? EXP_WR_BUSY : EXP_RD_BUSY);

        // Simultaneous request: the write wins, no read completion.
        run_access(1'b1, 1'b1, 24'h000010, 16'h1234, 18'h00010, EXP_WR_BUSY);
        run_access(1'b0, 1'b0, 24'h000010, 16'h1234, 18'h00010, EXP_RD_BUSY);

        // Reset in the middle of the write pulse.
        @(negedge clk);
        wr_enable = 1'b1; wr_addr = 24'h000040; wr_data = 16'h7777;
        @(negedge clk);
        wr_enable = 1'b0;
        @(negedge clk);
        check("abort_in_pulse", {31'd0, sram_we_n}, 32'd0);
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_strobes", {29'd0, sram_ce_n, sram_oe_n, sram_we_n}, 32'h7);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_rd_ready", {31'd0, rd_ready}, 32'd0);
        check("abort_sram_addr", {14'd0, sram_addr}, 32'd0);
        check("abort_dq_released", {31'd0, mdl_drive}, 32'd0);
        rst_n = 1'b1;
        run_access(1'b0, 1'b0, 24'h000041, 16'h2222, 18'h00041, EXP_RD_BUSY);
        run_access(1'b0, 1'b0, 24'h000123, 16'hBEEF, 18'h00123, EXP_RD_BUSY);

        check("wr_error_clean", {31'd0, wr_error}, 32'd0);
`ifdef SRAM_WRITE_VERIFY_EN
        stuck0 = 1'b1;
        run_access(1'b1, 1'b0, 24'h000050, 16'h0001, 18'h00050, 2 * W + 4);
        check("wr_error_set", {31'd0, wr_error}, 32'd1);
        run_access(1'b1, 1'b0, 24'h000050, 16'h0002, 18'h00050, 2 * W + 4);
        check("wr_error_sticky", {31'd0, wr_error}, 32'd1);
        stuck0 = 1'b0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
